fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the synchronous instruction ROM and downstream-feeds decode. It owns the PC and drives the ROM address. It absorbs the ROM's one-cycle read latency with a small buffer, then presents {pc, inst} packets to decode over a valid/ready handshake. Redirects from execute (branch/jump) flush the fetch pipe and restart fetching at the new target.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset.
FIFO_DEPTH, 2, packet buffer entries; must be a power of two and ≥2.

Ports:
CLK  input  1  clock; all state updates on posedge.
RST  input  1  synchronous, active-high reset.
IMEM_A  output  32  ROM byte address; the ROM returns RD one cycle later.
IMEM_RD  input  32  ROM read data for the address presented in the previous cycle.
OUT_VALID  output  1  packet available to decode.
OUT_READY  input  1  decode accepts the packet this cycle.
OUT_PC  output  32  PC of the presented instruction.
OUT_INST  output  32  presented instruction word.
REDIRECT_VALID  input  1  flush and restart request.
REDIRECT_PC  input  32  restart target.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: pc_q=RESET_PC, FIFO empty, inflight=0, OUT_VALID=0. OUT_PC and OUT_INST read 0 while OUT_VALID=0.
- No request is issued during a cycle in which RST=1.
- ROM latency: address on IMEM_A in cycle T, IMEM_RD valid in T+1.
- Response capture: in T+1 the response is written into the FIFO together with the PC that was latched at issue. The packet becomes visible on OUT_* in T+2.
- Issue rule: issue in a cycle iff RST=0 and (occupancy − pop + inflight_next_response) < FIFO_DEPTH.
  - pop = OUT_VALID & OUT_READY.
  - A response in flight always has a reserved slot, so no response is ever dropped for lack of space.
- On issue: IMEM_A=pc_q, pc_q<=pc_q+4, inflight<=1, req_pc<=pc_q. Otherwise inflight<=0.
- IMEM_A holds pc_q when not issuing; the ROM result is then ignored.
- Throughput: one packet per cycle with OUT_READY held high. Steady state from reset release: first OUT_VALID in cycle 2.
- Handshake:
  - OUT_PC and OUT_INST are stable while OUT_VALID=1 and OUT_READY=0.
  - OUT_VALID never drops without a pop, except on redirect or reset.
  - FIFO is first-in first-out; a push and a pop in the same cycle are both allowed when full.
- Redirect (REDIRECT_VALID=1 in cycle R):
  - FIFO is cleared at the end of R, so OUT_VALID=0 in R+1.
  - Any response arriving in R is discarded.
  - The new target is issued in R: IMEM_A=REDIRECT_PC with bits [1:0] forced to 00, pc_q<=target+4.
  - The first post-redirect packet appears in R+2.
  - A pop in R is a don't-care; decode must ignore OUT_* in R.
- Back-to-back redirects: the later target wins, and no packet from the earlier target is ever output.
- Redirect and RST together: RST wins.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0.
- Instruction data is passed through unaltered; 32'h0 from unmapped ROM addresses is forwarded as-is.
- RST mid-stream: everything returns to reset values on the next edge. A response already in flight is discarded because inflight is cleared.

Decomposition:
- Package shrv32_pkg holds:
  - XLEN=32.
  - INST_NOP=32'h0000_0013.
  - typedef struct packed {logic [31:0] pc; logic [31:0] inst;} fetch_pkt_t, shared with decode.
- Sub-module fetch_fifo: synchronous FIFO of fetch_pkt_t.
  - Ports: push, pop, flush, count, full/empty.
  - flush has priority over push.
- PC, issue logic and inflight tracking stay in fetch_unit.

Test Plan:
- Reset release, OUT_READY=1, ROM word0=00100f93, word1=0000408b, word2=01ffcfb3 → OUT_VALID first in cycle 2; packets (0,00100f93), (4,0000408b), (8,01ffcfb3) on consecutive cycles.
- OUT_READY=0 for 6 cycles mid-stream → at most FIFO_DEPTH packets buffered and IMEM_A frozen. After release, PCs continue +4 with no gap, duplicate or loss.
- FIFO full, REDIRECT_VALID with REDIRECT_PC=32'h20 (word8=21600023) → OUT_VALID=0 in R+1; (20,21600023) in R+2; no stale PC ever seen.
- Redirects on two consecutive cycles to 0x10 then 0x1C → first packet output is PC 0x1C; no PC 0x10 packet is ever output.
- Redirect to 32'h23 → IMEM_A=32'h20 and OUT_PC=32'h20. Redirect to 32'hFFFF_FFFC → next packet PCs are FFFF_FFFC, then 0.
- RST pulsed while FIFO has 2 entries and a request is in flight → OUT_VALID=0 the cycle after. Restart at RESET_PC with first packet 2 cycles after RST low; no pre-reset data emerges.

Source files
------------

// File: rtl/shrv32_pkg.sv
// Shared definitions for the shrv32 front end: data width, canonical NOP and the
// fetch-to-decode packet.
package shrv32_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch packets; flush empties it and overrides a push.
module fetch_fifo
   import shrv32_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_pkt_t               wr_data,
   output fetch_pkt_t               rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_pkt_t       mem_q [DEPTH];
   fetch_pkt_t       mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the synchronous ROM and buffers
// {pc, inst} packets for decode behind a valid/ready handshake.
module fetch_unit
   import shrv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic            CLK,
   input  logic            RST,
   output logic [XLEN-1:0] IMEM_A,
   input  logic [XLEN-1:0] IMEM_RD,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [XLEN-1:0] OUT_PC,
   output logic [XLEN-1:0] OUT_INST,
   input  logic            REDIRECT_VALID,
   input  logic [XLEN-1:0] REDIRECT_PC
);

   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned NEED_W = CNT_W + 1;

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  req_pc_q, req_pc_d;
   logic             inflight_q, inflight_d;
   logic [XLEN-1:0]  redirect_target;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             push;
   logic             space_ok;
   logic [NEED_W-1:0] need;
   fetch_pkt_t       wr_pkt;
   fetch_pkt_t       head_pkt;

   assign redirect_target = {REDIRECT_PC[XLEN-1:2], 2'b00};
   assign pop  = ~fifo_empty & OUT_READY;
   // A response landing in a redirect cycle belongs to the abandoned path.
   assign push = inflight_q & ~REDIRECT_VALID;

   // Slots committed after this cycle, counting the response now arriving.
   assign need     = NEED_W'(fifo_count) + NEED_W'(inflight_q) - NEED_W'(pop);
   assign space_ok = (need < NEED_W'(FIFO_DEPTH)) & ~(fifo_full & ~pop);

   always_comb begin
      IMEM_A     = pc_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = 1'b0;
      if (RST) begin
         pc_d = RESET_PC;
      end else if (REDIRECT_VALID) begin
         IMEM_A     = redirect_target;
         pc_d       = redirect_target + XLEN'(4);
         req_pc_d   = redirect_target;
         inflight_d = 1'b1;
      end else if (space_ok) begin
         pc_d       = pc_q + XLEN'(4);
         req_pc_d   = pc_q;
         inflight_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
      end
   end

   assign wr_pkt = '{pc: req_pc_q, inst: IMEM_RD};

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .push    (push),
      .pop     (pop),
      .flush   (REDIRECT_VALID),
      .wr_data (wr_pkt),
      .rd_data (head_pkt),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign OUT_VALID = ~fifo_empty;
   assign OUT_PC    = fifo_empty ? '0 : head_pkt.pc;
   assign OUT_INST  = fifo_empty ? '0 : head_pkt.inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written
// redirect and reset sequences against a behavioural one-cycle ROM.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] IMEM_A;
   logic [31:0] IMEM_RD;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] OUT_PC;
   logic [31:0] OUT_INST;
   logic        REDIRECT_VALID;
   logic [31:0] REDIRECT_PC;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic        rst;
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        chk_out;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] einst;
      logic [31:0] ea;
   } vec_t;

   vec_t vecs[$];

   fetch_unit dut (
      .CLK            (CLK),
      .RST            (RST),
      .IMEM_A         (IMEM_A),
      .IMEM_RD        (IMEM_RD),
      .OUT_VALID      (OUT_VALID),
      .OUT_READY      (OUT_READY),
      .OUT_PC         (OUT_PC),
      .OUT_INST       (OUT_INST),
      .REDIRECT_VALID (REDIRECT_VALID),
      .REDIRECT_PC    (REDIRECT_PC)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0010_0f93;
         32'h0000_0004: return 32'h0000_408b;
         32'h0000_0008: return 32'h01ff_cfb3;
         32'h0000_0020: return 32'h2160_0023;
         32'hFFFF_FFFC: return 32'hDEAD_BEEF;
         default:       return (a < 32'h100) ? {16'hA5A5, a[15:0]} : 32'h0;
      endcase
   endfunction

   always @(posedge CLK) IMEM_RD <= rom_word(IMEM_A);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   // Drive one cycle's inputs after the falling edge and let outputs settle.
   task automatic drive(input logic rst, input logic ready, input logic redir,
                        input logic [31:0] rpc);
      @(negedge CLK);
      RST            = rst;
      OUT_READY      = ready;
      REDIRECT_VALID = redir;
      REDIRECT_PC    = rpc;
      #2;
   endtask

   function automatic vec_t mk(input logic rst, input logic ready, input logic redir,
                               input logic [31:0] rpc, input logic chk_out, input logic ev,
                               input logic [31:0] epc, input logic [31:0] einst,
                               input logic [31:0] ea);
      vec_t v;
      v.rst = rst; v.ready = ready; v.redir = redir; v.rpc = rpc; v.chk_out = chk_out;
      v.ev = ev; v.epc = epc; v.einst = einst; v.ea = ea;
      return v;
   endfunction

   initial begin
      RST = 1'b1; OUT_READY = 1'b1; REDIRECT_VALID = 1'b0; REDIRECT_PC = '0;
      repeat (2) @(posedge CLK);

      // reset state, then startup stream
      vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 32'h00));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 32'h00));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 32'h04));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h00, 32'h0010_0f93, 32'h08));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h04, 32'h0000_408b, 32'h0C));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h08, 32'h01ff_cfb3, 32'h10));
      // six-cycle stall: head held, IMEM_A frozen
      for (int i = 0; i < 6; i++)
         vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h0C, 32'hA5A5_000C, 32'h14));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h0C, 32'hA5A5_000C, 32'h14));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h10, 32'hA5A5_0010, 32'h18));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h14, 32'hA5A5_0014, 32'h1C));
      // fill the buffer, then redirect to 0x20 while full
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h18, 32'hA5A5_0018, 32'h20));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h18, 32'hA5A5_0018, 32'h20));
      vecs.push_back(mk(0, 0, 1, 32'h20, 0, 0, 0, 0, 32'h20));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 32'h24));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h20, 32'h2160_0023, 32'h28));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h24, 32'hA5A5_0024, 32'h2C));
      // misaligned redirect target
      vecs.push_back(mk(0, 1, 1, 32'h23, 0, 0, 0, 0, 32'h20));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 32'h24));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h20, 32'h2160_0023, 32'h28));
      // PC wrap at the top of the address space
      vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 32'h00));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'h04));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h00, 32'h0010_0f93, 32'h08));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
         chk($sformatf("row%0d imem_a", i), IMEM_A, vecs[i].ea);
         if (vecs[i].chk_out) begin
            chk($sformatf("row%0d valid", i), 32'(OUT_VALID), 32'(vecs[i].ev));
            chk($sformatf("row%0d pc", i), OUT_PC, vecs[i].epc);
            chk($sformatf("row%0d inst", i), OUT_INST, vecs[i].einst);
         end
         @(posedge CLK);
      end

      // back-to-back redirects: 0x10 then 0x1C; 0x10 must never appear
      drive(0, 1, 1, 32'h10);
      chk("b2b first imem_a", IMEM_A, 32'h10);
      @(posedge CLK);
      drive(0, 1, 1, 32'h1C);
      chk("b2b second imem_a", IMEM_A, 32'h1C);
      @(posedge CLK);
      for (int k = 0; k < 6; k++) begin
         drive(0, 1, 0, 0);
         chk($sformatf("b2b k%0d valid", k), 32'(OUT_VALID), (k == 0) ? 32'd0 : 32'd1);
         if (k > 0) begin
            chk($sformatf("b2b k%0d pc", k), OUT_PC, 32'h1C + 32'(4 * (k - 1)));
            chk($sformatf("b2b k%0d inst", k), OUT_INST, rom_word(32'h1C + 32'(4 * (k - 1))));
         end
         @(posedge CLK);
      end

      // reset mid-stream with a simultaneous redirect: reset wins
      drive(1, 1, 1, 32'h40);
      @(posedge CLK);
      for (int k = 0; k < 6; k++) begin
         drive(0, 1, 0, 0);
         chk($sformatf("rst k%0d imem_a", k), IMEM_A, 32'(4 * k));
         chk($sformatf("rst k%0d valid", k), 32'(OUT_VALID), (k < 2) ? 32'd0 : 32'd1);
         chk($sformatf("rst k%0d pc", k), OUT_PC, (k < 2) ? 32'h0 : 32'(4 * (k - 2)));
         chk($sformatf("rst k%0d inst", k), OUT_INST,
             (k < 2) ? 32'h0 : rom_word(32'(4 * (k - 2))));
         @(posedge CLK);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
